// File: rtl/erx_distributor_pkg.sv
// Shared definitions for the RX distributor: channel codes and eMesh field widths.
package erx_distributor_pkg;

    localparam logic [1:0] CH_WR = 2'd0;
    localparam logic [1:0] CH_RQ = 2'd1;
    localparam logic [1:0] CH_RR = 2'd2;

    localparam int DATAMODE_W = 2;
    localparam int CTRLMODE_W = 4;

    // Read requests are the only non-writes; tagged writes are read responses.
    function automatic logic [1:0] classify(input logic write, input logic tag_hit);
        if (!write)       return CH_RQ;
        else if (tag_hit) return CH_RR;
        else              return CH_WR;
    endfunction

endpackage

// File: rtl/erx_distributor_if.sv
// eMesh ingress stream and the shared FIFO-side bus of the RX distributor.
interface erx_emesh_if
    import erx_distributor_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic                  access;
    logic                  write;
    logic [DATAMODE_W-1:0] datamode;
    logic [CTRLMODE_W-1:0] ctrlmode;
    logic [AW-1:0]         dstaddr;
    logic [AW-1:0]         srcaddr;
    logic [DW-1:0]         data;
    logic                  wait_req;

    modport master (output access, write, datamode, ctrlmode, dstaddr, srcaddr, data,
                    input  wait_req);
    modport slave  (input  access, write, datamode, ctrlmode, dstaddr, srcaddr, data,
                    output wait_req);
endinterface

interface erx_fifo_if
    import erx_distributor_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic                  write;
    logic [DATAMODE_W-1:0] datamode;
    logic [CTRLMODE_W-1:0] ctrlmode;
    logic [AW-1:0]         dstaddr;
    logic [AW-1:0]         srcaddr;
    logic [DW-1:0]         data;
    logic                  emwr_wr_en;
    logic                  emrq_wr_en;
    logic                  emrr_wr_en;
    logic                  emwr_progfull;
    logic                  emrq_progfull;
    logic                  emrr_progfull;

    modport master (output write, datamode, ctrlmode, dstaddr, srcaddr, data,
                           emwr_wr_en, emrq_wr_en, emrr_wr_en,
                    input  emwr_progfull, emrq_progfull, emrr_progfull);
    modport slave  (input  write, datamode, ctrlmode, dstaddr, srcaddr, data,
                           emwr_wr_en, emrq_wr_en, emrr_wr_en,
                    output emwr_progfull, emrq_progfull, emrr_progfull);
endinterface

// File: rtl/erx_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module erx_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // NOTE: clocked state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/erx_distributor.sv
// RX distributor: optional dstaddr remap, channel classification and a two-entry
// (output + skid) lossless buffer that stalls on the target FIFO's progfull.
module erx_distributor
    import erx_distributor_pkg::*;
#(
    parameter int                  AW            = 32,
    parameter int                  DW            = 32,
    parameter int                  TAG_BITS      = 12,
    parameter logic [TAG_BITS-1:0] READ_TAG_ADDR = 12'h810,
    parameter int                  REMAP_BITS    = 7,
    parameter logic [AW-1:0]       REMAP_ADDR    = 32'h3E000000,
    parameter int                  CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_enable,
    input  logic             remap_en,
    input  logic             cnt_clear,
    erx_emesh_if.slave       rx,
    erx_fifo_if.master       fifo,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rq_count,
    output logic [CNT_W-1:0] rr_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    typedef struct packed {
        logic [1:0]            ch;
        logic                  write;
        logic [DATAMODE_W-1:0] datamode;
        logic [CTRLMODE_W-1:0] ctrlmode;
        logic [AW-1:0]         dstaddr;
        logic [AW-1:0]         srcaddr;
        logic [DW-1:0]         data;
    } entry_t;

    logic [1:0] state, state_nxt;
    entry_t     in_entry, out_q, skid_q;
    logic       out_valid, skid_valid, accept, fire, stalled;
    logic       load_in, load_skid, promote;

    assign out_valid   = (state != S_EMPTY);
    assign skid_valid  = (state == S_TWO);
    assign accept      = rx.access & rx_enable & ~skid_valid;
    assign fire        = out_valid & ~stalled;
    assign rx.wait_req = skid_valid;

    // Tag compare looks at the address as it arrived, before any remap.
    always_comb begin
        in_entry.ch       = classify(rx.write, rx.dstaddr[AW-1 -: TAG_BITS] == READ_TAG_ADDR);
        in_entry.write    = rx.write;
        in_entry.datamode = rx.datamode;
        in_entry.ctrlmode = rx.ctrlmode;
        in_entry.dstaddr  = remap_en
                          ? {REMAP_ADDR[AW-1 -: REMAP_BITS], rx.dstaddr[AW-REMAP_BITS-1:0]}
                          : rx.dstaddr;
        in_entry.srcaddr  = rx.srcaddr;
        in_entry.data     = rx.data;
    end

    always_comb begin
        case (out_q.ch)
            CH_RQ:   stalled = fifo.emrq_progfull;
            CH_RR:   stalled = fifo.emrr_progfull;
            default: stalled = fifo.emwr_progfull;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        load_in   = 1'b0;
        load_skid = 1'b0;
        promote   = 1'b0;
        case (state)
            S_EMPTY: if (accept) begin
                state_nxt = S_ONE;
                load_in   = 1'b1;
            end
            S_ONE: begin
                if (accept && fire) begin
                    load_in = 1'b1;
                end else if (accept) begin
                    state_nxt = S_TWO;
                    load_skid = 1'b1;
                end else if (fire) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_TWO: if (fire) begin
                state_nxt = S_ONE;
                promote   = 1'b1;
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    // NOTE: the two entry registers are plain flops, so they are reset to zero for a clean bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_EMPTY;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            if (load_in)
                out_q <= in_entry;
            else if (promote)
                out_q <= skid_q;
            if (load_skid)
                skid_q <= in_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (cnt_clear)
            overflow <= 1'b0;
        else if (rx.access && skid_valid)
            overflow <= 1'b1;
    end

    logic wr_fire, rq_fire, rr_fire, drop;
    assign wr_fire = fire & (out_q.ch == CH_WR);
    assign rq_fire = fire & (out_q.ch == CH_RQ);
    assign rr_fire = fire & (out_q.ch == CH_RR);
    assign drop    = rx.access & ~rx_enable;

    assign fifo.write      = out_q.write;
    assign fifo.datamode   = out_q.datamode;
    assign fifo.ctrlmode   = out_q.ctrlmode;
    assign fifo.dstaddr    = out_q.dstaddr;
    assign fifo.srcaddr    = out_q.srcaddr;
    assign fifo.data       = out_q.data;
    assign fifo.emwr_wr_en = wr_fire;
    assign fifo.emrq_wr_en = rq_fire;
    assign fifo.emrr_wr_en = rr_fire;

    erx_sat_counter #(.CNT_W(CNT_W)) u_wr_cnt
        (.clk(clk), .reset(reset), .inc(wr_fire), .clr(cnt_clear), .count(wr_count));
    erx_sat_counter #(.CNT_W(CNT_W)) u_rq_cnt
        (.clk(clk), .reset(reset), .inc(rq_fire), .clr(cnt_clear), .count(rq_count));
    erx_sat_counter #(.CNT_W(CNT_W)) u_rr_cnt
        (.clk(clk), .reset(reset), .inc(rr_fire), .clr(cnt_clear), .count(rr_count));
    erx_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt
        (.clk(clk), .reset(reset), .inc(drop), .clr(cnt_clear), .count(drop_count));

endmodule

// File: tb/tb_erx_distributor.sv
// Directed bench for erx_distributor; counters built 4 bits wide to reach saturation quickly.
module tb_erx_distributor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_enable = 1'b1;
    logic       remap_en = 1'b0;
    logic       cnt_clear = 1'b0;
    logic [3:0] wr_count, rq_count, rr_count, drop_count;
    logic       overflow;
    int         errors = 0;
    int         checks = 0;

    erx_emesh_if #(.AW(32), .DW(32)) rx_if ();
    erx_fifo_if  #(.AW(32), .DW(32)) fifo_if ();

    erx_distributor #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .rx_enable(rx_enable), .remap_en(remap_en),
        .cnt_clear(cnt_clear), .rx(rx_if), .fifo(fifo_if),
        .wr_count(wr_count), .rq_count(rq_count), .rr_count(rr_count),
        .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic acc, input logic wr, input logic [31:0] dst,
                         input logic [31:0] dat);
        rx_if.access   = acc;
        rx_if.write    = wr;
        rx_if.dstaddr  = dst;
        rx_if.data     = dat;
        rx_if.srcaddr  = 32'h0000_1234;
        rx_if.datamode = 2'd2;
        rx_if.ctrlmode = 4'd0;
    endtask

    task automatic clear_counters();
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        fifo_if.emwr_progfull = 1'b0;
        fifo_if.emrq_progfull = 1'b0;
        fifo_if.emrr_progfull = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if ({fifo_if.emwr_wr_en, fifo_if.emrq_wr_en, fifo_if.emrr_wr_en} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b want 000", {fifo_if.emwr_wr_en, fifo_if.emrq_wr_en, fifo_if.emrr_wr_en}); end
        checks++; if (rx_if.wait_req !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b want 0", rx_if.wait_req); end
        checks++; if ({wr_count, rq_count, rr_count, drop_count} !== 16'h0) begin errors++; $display("FAIL reset_counts: got %h want 0000", {wr_count, rq_count, rr_count, drop_count}); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (fifo_if.dstaddr !== 32'h0 || fifo_if.data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h/%h want 0/0", fifo_if.dstaddr, fifo_if.data); end
    endtask

    task automatic test_single_write();
        clear_counters();
        drive(1'b1, 1'b1, 32'h8080_0000, 32'h11);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if ({fifo_if.emwr_wr_en, fifo_if.emrq_wr_en, fifo_if.emrr_wr_en} !== 3'b100) begin errors++; $display("FAIL single_strobes: got %b want 100", {fifo_if.emwr_wr_en, fifo_if.emrq_wr_en, fifo_if.emrr_wr_en}); end
        checks++; if (fifo_if.dstaddr !== 32'h8080_0000) begin errors++; $display("FAIL single_dst: got %h want 80800000", fifo_if.dstaddr); end
        checks++; if (fifo_if.data !== 32'h11 || fifo_if.srcaddr !== 32'h1234) begin errors++; $display("FAIL single_fields: got %h/%h want 11/1234", fifo_if.data, fifo_if.srcaddr); end
        tick();
        checks++; if (fifo_if.emwr_wr_en !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got %b want 0", fifo_if.emwr_wr_en); end
        checks++; if (wr_count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d want 1", wr_count); end
    endtask

    task automatic test_rr_rq();
        clear_counters();
        drive(1'b1, 1'b1, 32'h8100_0010, 32'h22);
        tick();
        drive(1'b1, 1'b0, 32'h0000_0020, 32'h33);
        checks++; if ({fifo_if.emwr_wr_en, fifo_if.emrq_wr_en, fifo_if.emrr_wr_en} !== 3'b001) begin errors++; $display("FAIL rr_strobes: got %b want 001", {fifo_if.emwr_wr_en, fifo_if.emrq_wr_en, fifo_if.emrr_wr_en}); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if ({fifo_if.emwr_wr_en, fifo_if.emrq_wr_en, fifo_if.emrr_wr_en} !== 3'b010) begin errors++; $display("FAIL rq_strobes: got %b want 010", {fifo_if.emwr_wr_en, fifo_if.emrq_wr_en, fifo_if.emrr_wr_en}); end
        checks++; if (fifo_if.write !== 1'b0 || fifo_if.data !== 32'h33) begin errors++; $display("FAIL rq_fields: got %b/%h want 0/33", fifo_if.write, fifo_if.data); end
        tick();
        checks++; if ({rr_count, rq_count, wr_count} !== 12'h110) begin errors++; $display("FAIL rr_rq_counts: got %h want 110", {rr_count, rq_count, wr_count}); end
    endtask

    task automatic test_remap();
        clear_counters();
        remap_en = 1'b1;
        drive(1'b1, 1'b1, 32'h8080_0004, 32'h44);
        tick();
        drive(1'b1, 1'b1, 32'h8100_0010, 32'h55);
        checks++; if (fifo_if.emwr_wr_en !== 1'b1 || fifo_if.dstaddr !== 32'h3E80_0004) begin errors++; $display("FAIL remap_wr: got en=%b dst=%h want en=1 dst=3e800004", fifo_if.emwr_wr_en, fifo_if.dstaddr); end
        tick();
        remap_en = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (fifo_if.emrr_wr_en !== 1'b1 || fifo_if.dstaddr !== 32'h3F00_0010) begin errors++; $display("FAIL remap_rr: got en=%b dst=%h want en=1 dst=3f000010", fifo_if.emrr_wr_en, fifo_if.dstaddr); end
        tick();
    endtask

    task automatic test_stall();
        clear_counters();
        fifo_if.emwr_progfull = 1'b1;
        drive(1'b1, 1'b1, 32'h0000_0100, 32'hA1);
        tick();
        checks++; if (rx_if.wait_req !== 1'b0 || fifo_if.emwr_wr_en !== 1'b0) begin errors++; $display("FAIL stall_one: got wait=%b en=%b want 0/0", rx_if.wait_req, fifo_if.emwr_wr_en); end
        drive(1'b1, 1'b1, 32'h0000_0104, 32'hA2);
        tick();
        checks++; if (rx_if.wait_req !== 1'b1) begin errors++; $display("FAIL stall_wait_rise: got %b want 1", rx_if.wait_req); end
        drive(1'b1, 1'b1, 32'h0000_0108, 32'hA3);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (overflow !== 1'b1 || rx_if.wait_req !== 1'b1) begin errors++; $display("FAIL stall_overflow: got ovf=%b wait=%b want 1/1", overflow, rx_if.wait_req); end
        tick();
        checks++; if (fifo_if.emwr_wr_en !== 1'b0 || fifo_if.data !== 32'hA1) begin errors++; $display("FAIL stall_hold: got en=%b data=%h want 0/a1", fifo_if.emwr_wr_en, fifo_if.data); end
        fifo_if.emwr_progfull = 1'b0;
        #1;
        checks++; if (fifo_if.emwr_wr_en !== 1'b1 || fifo_if.data !== 32'hA1) begin errors++; $display("FAIL stall_first: got en=%b data=%h want 1/a1", fifo_if.emwr_wr_en, fifo_if.data); end
        tick();
        checks++; if (fifo_if.emwr_wr_en !== 1'b1 || fifo_if.data !== 32'hA2 || rx_if.wait_req !== 1'b0) begin errors++; $display("FAIL stall_second: got en=%b data=%h wait=%b want 1/a2/0", fifo_if.emwr_wr_en, fifo_if.data, rx_if.wait_req); end
        tick();
        checks++; if (fifo_if.emwr_wr_en !== 1'b0 || wr_count !== 4'd2) begin errors++; $display("FAIL stall_drained: got en=%b cnt=%0d want 0/2", fifo_if.emwr_wr_en, wr_count); end
    endtask

    task automatic test_disable();
        clear_counters();
        fifo_if.emwr_progfull = 1'b1;
        drive(1'b1, 1'b1, 32'h0000_0200, 32'hC1);
        tick();
        rx_enable = 1'b0;
        fifo_if.emwr_progfull = 1'b0;
        drive(1'b1, 1'b1, 32'h0000_0204, 32'hC2);
        #1;
        checks++; if (fifo_if.emwr_wr_en !== 1'b1 || fifo_if.data !== 32'hC1) begin errors++; $display("FAIL disable_drain: got en=%b data=%h want 1/c1", fifo_if.emwr_wr_en, fifo_if.data); end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if ({fifo_if.emwr_wr_en, fifo_if.emrq_wr_en, fifo_if.emrr_wr_en} !== 3'b000) begin errors++; $display("FAIL disable_strobes_%0d: got %b want 000", i, {fifo_if.emwr_wr_en, fifo_if.emrq_wr_en, fifo_if.emrr_wr_en}); end
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        rx_enable = 1'b1;
        checks++; if (drop_count !== 4'd5 || wr_count !== 4'd1) begin errors++; $display("FAIL disable_counts: got drop=%0d wr=%0d want 5/1", drop_count, wr_count); end
    endtask

    task automatic test_saturation();
        clear_counters();
        drive(1'b1, 1'b0, 32'h0000_0300, 32'h0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 32'h0000_0400 + 32'(i), 32'(i));
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checks++; if (wr_count !== 4'hF || rq_count !== 4'd1) begin errors++; $display("FAIL sat_counts: got wr=%0d rq=%0d want 15/1", wr_count, rq_count); end
        rx_enable = 1'b0;
        drive(1'b1, 1'b1, 32'h0, 32'h0);
        tick();
        rx_enable = 1'b1;
        drive(1'b1, 1'b1, 32'h0000_0500, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        cnt_clear = 1'b1;
        checks++; if (fifo_if.emwr_wr_en !== 1'b1 || drop_count !== 4'd1) begin errors++; $display("FAIL clear_setup: got en=%b drop=%0d want 1/1", fifo_if.emwr_wr_en, drop_count); end
        tick();
        cnt_clear = 1'b0;
        checks++; if ({wr_count, rq_count, rr_count, drop_count} !== 16'h0 || overflow !== 1'b0) begin errors++; $display("FAIL clear_priority: got %h ovf=%b want 0000/0", {wr_count, rq_count, rr_count, drop_count}, overflow); end
    endtask

    task automatic test_reset_mid();
        clear_counters();
        fifo_if.emwr_progfull = 1'b1;
        drive(1'b1, 1'b1, 32'h0000_0600, 32'hD1);
        tick();
        drive(1'b1, 1'b1, 32'h0000_0604, 32'hD2);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (rx_if.wait_req !== 1'b1) begin errors++; $display("FAIL mid_two: got wait=%b want 1", rx_if.wait_req); end
        fifo_if.emwr_progfull = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (rx_if.wait_req !== 1'b0 || fifo_if.emwr_wr_en !== 1'b0) begin errors++; $display("FAIL mid_reset: got wait=%b en=%b want 0/0", rx_if.wait_req, fifo_if.emwr_wr_en); end
        tick();
        reset = 1'b0;
        tick();
        checks++; if ({fifo_if.emwr_wr_en, fifo_if.emrq_wr_en, fifo_if.emrr_wr_en} !== 3'b000 || wr_count !== 4'd0) begin errors++; $display("FAIL mid_after: got %b cnt=%0d want 000/0", {fifo_if.emwr_wr_en, fifo_if.emrq_wr_en, fifo_if.emrr_wr_en}, wr_count); end
        drive(1'b1, 1'b1, 32'h0000_0700, 32'hB);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (fifo_if.emwr_wr_en !== 1'b1 || fifo_if.data !== 32'hB) begin errors++; $display("FAIL mid_resume: got en=%b data=%h want 1/b", fifo_if.emwr_wr_en, fifo_if.data); end
        tick();
        checks++; if (wr_count !== 4'd1) begin errors++; $display("FAIL mid_count: got %0d want 1", wr_count); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_rr_rq();
        test_remap();
        test_stall();
        test_disable();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/erx_distributor.md
Name: erx_distributor

Overview:
- Parametrised successor to the RX filter/distributor: accepts one eMesh transaction stream (post-MMU), optionally remaps the destination address, and classifies each transaction to the write, read-request or read-response FIFO.
- Adds lossless back-pressure: a 1-entry skid buffer and output hold stall on the target FIFO's progfull, so transactions are never dropped.
- Adds enable gating, overflow detection and per-channel saturating transaction counters for debug.
- Sits between the RX MMU and the three RX master FIFOs.

Parameters:
- AW, 32, address width (dstaddr/srcaddr)
- DW, 32, data width
- TAG_BITS, 12, number of dstaddr MSBs compared against READ_TAG_ADDR
- READ_TAG_ADDR, 12'h810, dstaddr[AW-1:AW-TAG_BITS] value identifying a read response
- REMAP_BITS, 7, number of dstaddr MSBs replaced in static remap mode (1..AW-1)
- REMAP_ADDR, 32'h3E000000, source of the replacement MSBs
- CNT_W, 16, counter width

Ports:
- clk  in  1  RX clock
- reset  in  1  async active-high reset
- rx_enable  in  1  0: incoming accesses are discarded
- remap_en  in  1  1: static remap; 0: pass dstaddr unchanged
- cnt_clear  in  1  synchronous clear of all counters and the overflow flag
- in_access  in  1  transaction valid
- in_write  in  1  write (1) / read request (0)
- in_datamode  in  2
- in_ctrlmode  in  4
- in_dstaddr  in  AW
- in_srcaddr  in  AW
- in_data  in  DW
- in_wait  out  1  upstream must not assert in_access while high
- out_write, out_datamode, out_ctrlmode, out_dstaddr, out_srcaddr, out_data  out  1/2/4/AW/AW/DW  shared transaction to all FIFOs
- emwr_wr_en, emrq_wr_en, emrr_wr_en  out  1 each  FIFO write strobes
- emwr_progfull, emrq_progfull, emrr_progfull  in  1 each  per-channel stall
- wr_count, rq_count, rr_count  out  CNT_W each  fired transactions per channel
- drop_count  out  CNT_W  accesses discarded by rx_enable=0
- overflow  out  1  sticky: access arrived while in_wait was high

Behaviour:
- Classification at input, stored as 2-bit channel code with the entry:
  - in_write=0: RQ
  - in_write=1 and dstaddr tag == READ_TAG_ADDR: RR
  - otherwise: WR
  - Tag compare uses the un-remapped address.
- Remap at input when remap_en=1: dstaddr = {REMAP_ADDR[AW-1:AW-REMAP_BITS], in_dstaddr[AW-1-REMAP_BITS:0]}.
- Storage: output register (out_valid) plus skid register (skid_valid). State is EMPTY, ONE or TWO.
- fire = out_valid & ~progfull[channel]. Strobe for the stored channel = fire, combinational from registers; all other strobes are 0.
- Accept = in_access & rx_enable & ~in_wait.
- Transitions:
  - EMPTY + accept: ONE.
  - ONE + accept & ~fire: TWO (new entry goes to skid).
  - ONE + accept & fire: ONE (new entry loads output).
  - ONE + fire only: EMPTY.
  - TWO + fire: ONE (skid moves to output).
  - TWO never accepts.
- in_wait = skid_valid (registered).
- Latency: accept at edge k gives data and strobe in cycle k+1 if not stalled.
- Order is strictly preserved; a stalled head blocks later entries for all channels.
- Output fields hold their value while not fired and are undefined-but-stable after firing.
- in_access while in_wait high: the transaction is discarded, overflow is set, state is unchanged.
- in_access with rx_enable=0: discarded, drop_count increments. Stored entries still drain.
- Counters:
  - Increment by 1 per fire on the matching channel.
  - Saturate at all-ones; no wrap.
  - cnt_clear takes priority over increment in the same cycle.
- Reset:
  - State is EMPTY and all strobes are 0.
  - in_wait=0, counters=0, overflow=0.
  - Data registers reset to 0.
  - Reset mid-operation discards stored entries without firing.

Decomposition:
- Shared package: channel code constants (CH_WR=0, CH_RQ=1, CH_RR=2) and the transaction field widths.
- One natural sub-module, erx_sat_counter (CNT_W, inc, clr, saturate), instantiated 4×.

Test Plan:
- Single write, dst 0x80800000, no stall: emwr_wr_en high exactly one cycle after accept, out_dstaddr=0x80800000, wr_count=1.
- Write to 0x81000010, then read request: emrr_wr_en then emrq_wr_en on consecutive cycles; rr_count=1, rq_count=1.
- remap_en=1, dst 0x80800004: out_dstaddr=0x3E800004 (top 7 bits from REMAP_ADDR); classified WR.
- emwr_progfull high, 3 back-to-back writes:
  - in_wait rises after the 2nd accept.
  - The 3rd access (sent despite in_wait) is discarded and overflow=1.
  - After progfull drops, exactly 2 strobes fire, in original order.
- rx_enable=0 with 5 accesses: no strobes, drop_count=5. Preload with CNT_W=4 and fire 20 writes: wr_count saturates at 15. cnt_clear resets all counters to 0.
- Assert reset while in state TWO: no strobes afterwards, in_wait=0; the next access fires normally after one cycle.
